// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver/transmitter state enum, the default
// bit period and the 12-bit bit-period type used by usart_rx and usart_tx.
package usart_pkg;

    // Bit period (in serial_clock cycles) used when clocks_per_bit is 0.
    localparam int DEFAULT_CLOCKS_PER_BIT = 32;

    // Bit period / cycle counter width shared by receiver and transmitter.
    typedef logic [11:0] bit_period_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } usart_state_e;

    // A zero request selects the default period; anything else is used as-is.
    function automatic bit_period_t effective_period(input bit_period_t requested,
                                                     input bit_period_t fallback);
        return (requested == '0) ? fallback : requested;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset
// value is a parameter so an idle-high line does not look like an edge.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is used by downstream logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usart_rx.sv
// USART asynchronous receiver, 8 data bits, LSB first, one stop bit.
// Bytes are offered on a valid/ready handshake through a single holding
// register; rts_pin mirrors "holding register full".
//
// Handshake: data_out is consumed on any rising edge where valid && ready
// are both high; valid drops on that edge unless a new byte completes on
// the same edge, in which case the new byte is presented and valid stays.
//
// Build option: define USART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit.
module usart_rx #(
    parameter int DEFAULT_CLOCKS_PER_BIT = usart_pkg::DEFAULT_CLOCKS_PER_BIT,
    parameter int DATA_BITS              = 8
) (
    input  logic                   serial_clock,
    input  logic                   reset,
    input  logic [11:0]            clocks_per_bit,
    output logic [DATA_BITS-1:0]   data_out,
    output logic                   valid,
    input  logic                   ready,
    output logic                   error,
    input  logic                   rx_pin,
    output logic                   rts_pin,
    output usart_pkg::usart_state_e state_dbg
);

    import usart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 line_s;
    logic                 line_prev_q;
    usart_state_e         state_q;
    bit_period_t          cnt_q;
    bit_period_t          period_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 error_q;
    logic                 rts_q;
`ifdef USART_RX_PARITY_EN
    logic                 parity_err_q;
`endif

    bit_period_t          period_d;
    logic [12:0]          cnt_next;
    logic                 half_done;
    logic                 bit_done;
    logic                 consume;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk_i (serial_clock),
        .rst_i (reset),
        .d_i   (rx_pin),
        .q_o   (line_s)
    );

    // Period and counter terminal conditions. Comparisons are ">=" on a
    // 13-bit count so tiny (unsupported) periods still terminate.
    always_comb begin
        period_d  = effective_period(clocks_per_bit, bit_period_t'(DEFAULT_CLOCKS_PER_BIT));
        cnt_next  = {1'b0, cnt_q} + 13'd1;
        half_done = cnt_next >= {2'b00, period_q[11:1]};
        bit_done  = cnt_next >= {1'b0, period_q};
        consume   = valid_q && ready;
    end

    // Receive state machine with its counters, shift register and outputs.
    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            line_prev_q  <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= bit_period_t'(DEFAULT_CLOCKS_PER_BIT);
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            rts_q        <= 1'b0;
`ifdef USART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            line_prev_q <= line_s;

            // Consumption; a byte completing this cycle overrides it below.
            if (consume) begin
                valid_q <= 1'b0;
                rts_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (line_prev_q && !line_s) begin
                        state_q  <= START;
                        period_q <= period_d;
                        cnt_q    <= '0;
                    end
                end

                START: begin
                    if (half_done) begin
                        cnt_q <= '0;
                        if (!line_s) begin
                            state_q      <= DATA;
                            bit_idx_q    <= '0;
                            error_q      <= 1'b0;
`ifdef USART_RX_PARITY_EN
                            parity_err_q <= 1'b0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= line_s;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef USART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end

`ifdef USART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt_q        <= '0;
                        // Even parity: data ones plus parity bit must be even.
                        parity_err_q <= (^shift_q) ^ line_s;
                        state_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (line_s) begin
                            state_q <= IDLE;
`ifdef USART_RX_PARITY_EN
                            if (parity_err_q) begin
                                error_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                rts_q   <= 1'b1;
                                if (valid_q && !ready) error_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            rts_q   <= 1'b1;
                            if (valid_q && !ready) error_q <= 1'b1;
`endif
                        end else begin
                            // Framing error: byte is shown but not offered.
                            error_q <= 1'b1;
                            data_q  <= shift_q;
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end

                WAIT_IDLE: begin
                    if (line_s) state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign rts_pin   = rts_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx: directed scenarios followed by random
// frames, all compared against a frame-level reference model.
module tb_usart_rx;
    import usart_pkg::*;

    logic         serial_clock = 1'b0;
    logic         reset;
    logic [11:0]  clocks_per_bit;
    logic [7:0]   data_out;
    logic         valid;
    logic         ready;
    logic         error;
    logic         rx_pin;
    logic         rts_pin;
    usart_state_e state_dbg;

    usart_rx dut (
        .serial_clock   (serial_clock),
        .reset          (reset),
        .clocks_per_bit (clocks_per_bit),
        .data_out       (data_out),
        .valid          (valid),
        .ready          (ready),
        .error          (error),
        .rx_pin         (rx_pin),
        .rts_pin        (rts_pin),
        .state_dbg      (state_dbg)
    );

    // Clock: period 4 time units.
    always #2 serial_clock = ~serial_clock;

    // Scoreboard state.
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];       // good bytes delivered and not yet consumed
    logic [7:0] exp_data;       // byte expected on data_out
    logic       exp_error;
    int         bit_time = 128;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_valid;
        exp_valid = (exp_q.size() != 0);
        @(negedge serial_clock);
        check_eq({tag, ".data"},  32'(data_out), 32'(exp_data));
        check_eq({tag, ".valid"}, 32'(valid),    32'(exp_valid));
        check_eq({tag, ".error"}, 32'(error),    32'(exp_error));
        check_eq({tag, ".rts"},   32'(rts_pin),  32'(exp_valid));
    endtask

    // Reference model: effect of one complete frame on the holding register.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        exp_data = b;
        if (stop_bit) begin
            exp_error = (exp_q.size() != 0);   // unconsumed byte -> overrun
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back(b);
        end else begin
            exp_error = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_data  = 8'h00;
        exp_error = 1'b0;
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit; line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_pin = 1'b0;
        #(bit_time);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            #(bit_time);
        end
        rx_pin = stop_bit;
        #(bit_time);
        model_frame(b, stop_bit);
    endtask

    // One-cycle ready pulse; the byte seen at consumption is scoreboarded.
    task automatic consume(input string tag);
        @(negedge serial_clock);
        if (exp_q.size() != 0) check_eq({tag, ".consumed"}, 32'(data_out), 32'(exp_q.pop_front()));
        ready = 1'b1;
        @(negedge serial_clock);
        ready = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic        bad;
        logic [11:0] cpb;

        reset          = 1'b1;
        rx_pin         = 1'b1;
        ready          = 1'b0;
        clocks_per_bit = 12'd0;
        model_reset();
        repeat (5) @(posedge serial_clock);
        check_outputs("reset");
        check_eq("reset.state", 32'(state_dbg), 32'(IDLE));
        @(negedge serial_clock);
        reset = 1'b0;
        #(2 * bit_time);

        // Good frame 0x75, then consume it.
        send_frame(8'h75, 1'b1);
        #20;
        check_outputs("frame75");
        consume("frame75_rd");

        // Framing error 0xF5 with line held low.
        send_frame(8'hF5, 1'b0);
        #20;
        check_outputs("framing");
        #(3 * bit_time);
        check_outputs("framing_low");
        check_eq("framing.state", 32'(state_dbg), 32'(WAIT_IDLE));
        rx_pin = 1'b1;
        #(2 * bit_time);
        send_frame(8'h3A, 1'b1);
        #20;
        check_outputs("recover");

        // Short low glitch on idle line: nothing changes.
        rx_pin = 1'b0;
        #40;
        rx_pin = 1'b1;
        #(bit_time);
        check_outputs("glitch");
        check_eq("glitch.state", 32'(state_dbg), 32'(IDLE));
        consume("glitch_rd");

        // Overrun: two frames without consumption.
        send_frame(8'h75, 1'b1);
        #20;
        send_frame(8'h3C, 1'b1);
        #20;
        check_outputs("overrun");
        consume("overrun_rd");

        // Reset in the middle of the data bits.
        rx_pin = 1'b0;
        #(bit_time);
        rx_pin = 1'b1;
        #(bit_time);
        rx_pin = 1'b0;
        #(bit_time);
        rx_pin = 1'b1;
        #(bit_time / 2);
        reset = 1'b1;
        model_reset();
        #20;
        check_outputs("midreset");
        check_eq("midreset.state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        #(2 * bit_time);
        send_frame(8'hA5, 1'b1);
        #20;
        check_outputs("afterreset");
        consume("afterreset_rd");

        // Random frames, bit periods and consumption pattern.
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 3))
                0:       cpb = 12'd0;
                1:       cpb = 12'd16;
                2:       cpb = 12'd24;
                default: cpb = 12'd40;
            endcase
            clocks_per_bit = cpb;
            bit_time = 4 * ((cpb == 12'd0) ? DEFAULT_CLOCKS_PER_BIT : int'(cpb));
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            if (bad && exp_q.size() != 0) consume("rand_pre");
            #(bit_time);
            send_frame(b, !bad);
            #20;
            check_outputs("rand");
            if (bad) begin
                #(2 * bit_time);
                check_outputs("rand_low");
                rx_pin = 1'b1;
                #(bit_time);
            end
            if ($urandom_range(0, 1) == 1) consume("rand_rd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
